// File: rtl/objects_mux_arbiter.sv
// Per-pixel colour arbiter between the background and up to eight object drawers,
// with per-frame player collision detection against objects and border lines.
module objects_mux_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic [NUM_REQ-1:0]   drawingRequest,
   input  logic [8*NUM_REQ-1:0] objRGB,
   input  logic [7:0]           BG_RGB,
   input  logic                 boardersDR,
   output logic [7:0]           RGBOut,
   output logic [3:0]           winnerIdx,
   output logic                 collision,
   output logic [NUM_REQ:0]     collisionMask
);

   localparam logic [3:0] BG_IDX = 4'hF;

   logic [7:0]       win_rgb;
   logic [3:0]       win_idx;
   logic [NUM_REQ:0] hit;
   logic             any_hit;
   logic [NUM_REQ:0] acc_mask;
   logic             pulsed_this_frame;

   // Scanning from the highest index down lets the lowest active index win.
   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      win_rgb = BG_RGB;
      win_idx = BG_IDX;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (drawingRequest[i]) begin
            win_rgb = objRGB[8*i +: 8];
            win_idx = 4'(i);
         end
      end
   end

   // Bit 0 stays clear: the player cannot collide with itself.
   always_comb begin
      hit = '0;
      for (int i = 1; i < NUM_REQ; i++) begin
         hit[i] = drawingRequest[0] & drawingRequest[i];
      end
      hit[NUM_REQ] = drawingRequest[0] & boardersDR;
   end

   assign any_hit = |hit;

   // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         RGBOut    <= 8'h00;
         winnerIdx <= BG_IDX;
      end else begin
         RGBOut    <= win_rgb;
         winnerIdx <= win_idx;
      end
   end

   // Hits seen in the startOfFrame cycle already belong to the new frame.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         acc_mask          <= '0;
         collisionMask     <= '0;
         pulsed_this_frame <= 1'b0;
         collision         <= 1'b0;
      end else begin
         collision <= any_hit & (startOfFrame | ~pulsed_this_frame);
         if (startOfFrame) begin
            acc_mask          <= hit;
            collisionMask     <= acc_mask;
            pulsed_this_frame <= any_hit;
         end else begin
            acc_mask          <= acc_mask | hit;
            pulsed_this_frame <= pulsed_this_frame | any_hit;
         end
      end
   end

endmodule
